fetch_stage: RTL

Instruction fetch stage feeding the IF/ID pipeline register. Owns the program counter, issues one request per cycle to a fixed one-cycle-latency instruction memory, and buffers returned words with their PCs in a small queue so a decode-side stall never loses an in-flight instruction. The outputs map directly onto the IF/ID fields `Curr_Pc` and `Curr_Instr`. Branch/jump redirects from the execute stage flush the queue and restart fetch at the target.

---
 rtl/fetch_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues to a 1-cycle imem, queues {pc, instr} for IF/ID.
// Latency: 2 cycles from request to Curr_Pc/Curr_Instr; redirect costs 2 bubble cycles.
// Backpressure: stall holds the queue head; requests stop once queue + in-flight would overflow.

// Small synchronous FIFO with flush; simultaneous push/pop allowed even when full.
// Latency: 1 cycle from push to head_vld (head is a registered-storage mux).
// Backpressure: pushes are ignored when full without a same-cycle pop; the caller prevents that.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    input  logic             pop_vld,
    output logic             head_vld,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] cnt
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_vld = (cnt != '0);
    assign full     = (cnt == CNT_W'(DEPTH));
    assign head_dat = mem[rd_ptr];

    // A flush or reset suppresses both operations; a pop frees the slot a full-queue push needs.
    assign do_pop  = reset_n & ~flush & pop_vld & head_vld;
    assign do_push = reset_n & ~flush & push_vld & (~full | do_pop);

    // Entry storage: written at the tail; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

module fetch_stage #(
    parameter int             PC_W      = 9,
    parameter int             INSTR_W   = 32,
    parameter int             DEPTH     = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               stall,
    output logic               if_valid,
    output logic [PC_W-1:0]    Curr_Pc,
    output logic [INSTR_W-1:0] Curr_Instr
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pend_pc;
    logic             inflight;
    logic             pop;
    logic             issue_room;
    logic [CNT_W-1:0] fq_cnt;
    logic             fq_head_vld;
    fq_entry_t        fq_head;
    fq_entry_t        fq_push_dat;
    logic             redirect_pc_lsb_unused;

    // Targets are word aligned; the low address bits of a redirect carry no information.
    assign redirect_pc_lsb_unused = ^redirect_pc[1:0];

    assign pop = fq_head_vld & ~stall;

    // Issue only when every slot already promised (queued + in flight) still leaves one free
    // after this cycle's pop, so a returning word always has room.
    assign issue_room = (OCC_W'(fq_cnt) + OCC_W'(inflight)) < (OCC_W'(DEPTH) + OCC_W'(pop));

    assign imem_req  = reset_n & ~redirect & issue_room;
    assign imem_addr = pc;

    // PC, pending-request PC and in-flight flag; redirect overrides any issue this cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc       <= '0;
            pend_pc  <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            pc       <= {redirect_pc[PC_W-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pend_pc <= pc;
                pc      <= pc + PC_W'(4);
            end
        end
    end

    assign fq_push_dat = '{pc: pend_pc, instr: imem_rdata};

    sync_fifo #(
        .W     (PC_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fq (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (redirect),
        .push_vld (inflight & ~redirect),
        .push_dat (fq_push_dat),
        .pop_vld  (pop),
        .head_vld (fq_head_vld),
        .head_dat (fq_head),
        .cnt      (fq_cnt)
    );

    // IF/ID fields come only from the queue head, never straight from imem_rdata.
    assign if_valid   = fq_head_vld;
    assign Curr_Pc    = fq_head_vld ? fq_head.pc    : '0;
    assign Curr_Instr = fq_head_vld ? fq_head.instr : NOP_INSTR;

endmodule
